// File: rtl/led_ctrl_pkg.sv
// Shared types and helpers for the LED array controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF  = 2'd0,
    LED_ON   = 2'd1,
    LED_SLOW = 2'd2,
    LED_FAST = 2'd3
  } led_mode_t;

  // Serial frame width: 2 mode bits followed by the address field.
  function automatic int unsigned frame_w(input int unsigned addr_w);
    return 32'(addr_w + 32'd2);
  endfunction

endpackage

// File: rtl/led_serial_rx.sv
// Serial frame receiver: pin synchronisers, edge detection, shift register
// and bit counter. Presents the decoded frame fields and a commit strobe.
module led_serial_rx
  import led_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              sdata,
  input  logic              latch,
  output logic              commit_c,
  output logic              len_ok_c,
  output led_mode_t         mode,
  output logic [ADDR_W-1:0] addr
);

  localparam int unsigned FW   = frame_w(ADDR_W);
  localparam int unsigned BC_W = $clog2(FW + 2);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(FW);
  localparam logic [BC_W-1:0] BC_SAT  = BC_W'(FW + 1);

  // [0] metastable stage, [1] synced value, [2] previous synced value
  logic [2:0]      sclk_q;
  logic [2:0]      latch_q;
  logic [1:0]      sdata_q;
  logic [FW-1:0]   sr;
  logic [BC_W-1:0] bc;

  logic sclk_rise;
  logic latch_rise;
  logic latch_fall;
  logic bit_take;

  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign latch_rise = latch_q[1] & ~latch_q[2];
  assign latch_fall = ~latch_q[1] & latch_q[2];
  assign bit_take   = sclk_rise & latch_q[1];

  // Two-flop synchronisers plus one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q  <= '0;
      latch_q <= '0;
      sdata_q <= '0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      latch_q <= {latch_q[1:0], latch};
      sdata_q <= {sdata_q[0], sdata};
    end
  end

  // Shift accepted bits in MSB first; count them, saturating past a full frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
      bc <= '0;
    end else begin
      if (bit_take) begin
        sr <= {sr[FW-2:0], sdata_q[1]};
      end
      if (latch_rise) begin
        bc <= '0;
      end else if (bit_take && (bc != BC_SAT)) begin
        bc <= bc + BC_W'(1);
      end
    end
  end

  assign commit_c = latch_fall;
  assign len_ok_c = (bc == BC_FULL);
  assign mode     = led_mode_t'(sr[FW-1:FW-2]);
  assign addr     = sr[ADDR_W-1:0];

endmodule

// File: rtl/led_array_ctrl.sv
// Serial-programmed LED array controller with internal blink generator.
// Optional broadcast write to the all-ones address: LED_ARRAY_CTRL_BCAST_EN.
module led_array_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned N_LEDS = 21,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              sdata,
  input  logic              latch,
  output logic [N_LEDS-1:0] led,
  output logic              frame_ok,
  output logic              frame_err
);

  localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(N_LEDS);

  logic              commit_c;
  logic              len_ok_c;
  led_mode_t         rx_mode;
  logic [ADDR_W-1:0] rx_addr;

  led_mode_t         mode_q [N_LEDS];
  logic [CNT_W-1:0]  cnt;
  logic [N_LEDS-1:0] led_nxt_c;
  logic              slow_c;
  logic              fast_c;

  led_serial_rx #(
    .ADDR_W (ADDR_W)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .sdata    (sdata),
    .latch    (latch),
    .commit_c (commit_c),
    .len_ok_c (len_ok_c),
    .mode     (rx_mode),
    .addr     (rx_addr)
  );

  // Free-running blink prescaler; all blinking LEDs share its phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign slow_c = cnt[CNT_W-1];
  assign fast_c = cnt[CNT_W-3];

  // Frame decode: length check, then single write, broadcast or reject
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_LEDS); i++) begin
        mode_q[i] <= LED_OFF;
      end
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      if (commit_c) begin
        if (!len_ok_c) begin
          frame_err <= 1'b1;
        end else if (rx_addr < ADDR_LIM) begin
          mode_q[rx_addr] <= rx_mode;
          frame_ok        <= 1'b1;
        end
`ifdef LED_ARRAY_CTRL_BCAST_EN
        else if (rx_addr == '1) begin
          for (int i = 0; i < int'(N_LEDS); i++) begin
            mode_q[i] <= rx_mode;
          end
          frame_ok <= 1'b1;
        end
`endif
        else begin
          frame_err <= 1'b1;
        end
      end
    end
  end

  // Per-LED drive selection from mode and pattern bits
  always_comb begin
    led_nxt_c = '0;
    for (int i = 0; i < int'(N_LEDS); i++) begin
      case (mode_q[i])
        LED_ON:   led_nxt_c[i] = 1'b1;
        LED_SLOW: led_nxt_c[i] = slow_c;
        LED_FAST: led_nxt_c[i] = fast_c;
        default:  led_nxt_c[i] = 1'b0;
      endcase
    end
  end

  // Registered LED outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_nxt_c;
    end
  end

endmodule

// File: tb/tb_led_array_ctrl.sv
// Self-checking bench for led_array_ctrl (N_LEDS=21, ADDR_W=5, CNT_W=4).
`timescale 1ns/1ps
module tb_led_array_ctrl;

  localparam int N_LEDS = 21;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 4;
  localparam int FW     = 7;
  localparam int PH     = 4;

  typedef struct {
    int                n_ok;
    int                n_err;
    int                first;
    int                k3;
    logic [N_LEDS-1:0] led3;
    logic [N_LEDS-1:0] led4;
  } obs_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sclk;
  logic              sdata;
  logic              latch;
  logic [N_LEDS-1:0] led;
  logic              frame_ok;
  logic              frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int tick;
  int model [N_LEDS];

  always #5 clk = ~clk;

  // Clock edges since reset release: the prescaler value follows this count
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick <= 0;
    else        tick <= tick + 1;
  end

  led_array_ctrl #(
    .N_LEDS (N_LEDS),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .sdata     (sdata),
    .latch     (latch),
    .led       (led),
    .frame_ok  (frame_ok),
    .frame_err (frame_err)
  );

  // Expected LED vector after clock edge k: driven by the prescaler value before that edge
  function automatic logic [N_LEDS-1:0] exp_led(input int k);
    int c;
    logic [N_LEDS-1:0] v;
    c = (k - 1) & ((1 << CNT_W) - 1);
    v = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      case (model[i])
        1:       v[i] = 1'b1;
        2:       v[i] = 1'((c >> (CNT_W - 1)) & 1);
        3:       v[i] = 1'((c >> (CNT_W - 3)) & 1);
        default: v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  // Outcome rule: 0 = reject, 1 = single write, 2 = broadcast
  function automatic int outcome(input logic [15:0] bits, input int nbits);
    int a;
    a = int'(bits[4:0]);
    if (nbits != FW) return 0;
    if (a < N_LEDS) return 1;
`ifdef LED_ARRAY_CTRL_BCAST_EN
    if (a == 31) return 2;
`endif
    return 0;
  endfunction

  function automatic void apply_model(input logic [15:0] bits, input int nbits);
    int oc;
    oc = outcome(bits, nbits);
    if (oc == 1) model[int'(bits[4:0])] = int'(bits[6:5]);
    if (oc == 2) for (int i = 0; i < N_LEDS; i++) model[i] = int'(bits[6:5]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; sclk = 1'b0; latch = 1'b0; sdata = 1'b0;
    for (int i = 0; i < N_LEDS; i++) model[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_bits(input logic [15:0] bits, input int nbits);
    for (int j = nbits - 1; j >= 0; j--) begin
      sdata = bits[j];
      repeat (PH) @(negedge clk);
      sclk = 1'b1;
      repeat (PH) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  // Send a frame, drop latch, then observe the commit window (10 samples)
  task automatic run_frame(input logic [15:0] bits, input int nbits, output obs_t o);
    @(negedge clk);
    latch = 1'b1; sclk = 1'b0;
    repeat (PH) @(negedge clk);
    send_bits(bits, nbits);
    repeat (PH) @(negedge clk);
    latch = 1'b0;
    o.n_ok = 0; o.n_err = 0; o.first = -1; o.k3 = 0; o.led3 = '0; o.led4 = '0;
    for (int s = 1; s <= 10; s++) begin
      @(negedge clk);
      if (frame_ok)  o.n_ok++;
      if (frame_err) o.n_err++;
      if ((frame_ok || frame_err) && o.first < 0) o.first = s;
      if (s == 3) begin o.led3 = led; o.k3 = tick; end
      if (s == 4) o.led4 = led;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0; sclk = 1'b0; latch = 1'b0; sdata = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (led !== '0 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state led=%h ok=%b err=%b expected 0/0/0", led, frame_ok, frame_err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < N_LEDS; i++) model[i] = 0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (led !== '0 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset led=%h ok=%b err=%b expected 0/0/0", led, frame_ok, frame_err);
    end
  endtask

  task automatic test_single_on();
    obs_t o;
    do_reset();
    run_frame(16'b01_00011, 7, o);
    n_cmp++;
    if (o.n_ok !== 1 || o.n_err !== 0 || o.first !== 3) begin
      n_bad++;
      $display("FAIL single_commit ok=%0d err=%0d at=%0d expected 1/0/3", o.n_ok, o.n_err, o.first);
    end
    n_cmp++;
    if (o.led3 !== 21'h0 || o.led4 !== 21'h000008) begin
      n_bad++;
      $display("FAIL single_led led3=%h led4=%h expected 000000/000008", o.led3, o.led4);
    end
    apply_model(16'b01_00011, 7);
  endtask

  task automatic test_blink();
    obs_t o;
    logic [N_LEDS-1:0] prev;
    int c0, c1, mis;
    do_reset();
    run_frame(16'b11_00000, 7, o);
    n_cmp++;
    if (o.n_ok !== 1 || o.n_err !== 0 || o.first !== 3) begin
      n_bad++;
      $display("FAIL blink_fast_commit ok=%0d err=%0d at=%0d expected 1/0/3", o.n_ok, o.n_err, o.first);
    end
    apply_model(16'b11_00000, 7);
    run_frame(16'b10_00001, 7, o);
    n_cmp++;
    if (o.n_ok !== 1 || o.n_err !== 0 || o.first !== 3) begin
      n_bad++;
      $display("FAIL blink_slow_commit ok=%0d err=%0d at=%0d expected 1/0/3", o.n_ok, o.n_err, o.first);
    end
    apply_model(16'b10_00001, 7);
    prev = led; c0 = 0; c1 = 0; mis = 0;
    for (int s = 0; s < 32; s++) begin
      @(negedge clk);
      if (led[0] != prev[0]) c0++;
      if (led[1] != prev[1]) begin c1++; if (led[0] == prev[0]) mis++; end
      prev = led;
      n_cmp++;
      if (led !== exp_led(tick)) begin
        n_bad++;
        $display("FAIL blink_led s=%0d led=%h expected %h", s, led, exp_led(tick));
      end
    end
    n_cmp++;
    if (c0 != 16 || c1 != 4 || mis != 0) begin
      n_bad++;
      $display("FAIL blink_toggles fast=%0d slow=%0d misaligned=%0d expected 16/4/0", c0, c1, mis);
    end
  endtask

  task automatic test_bad_frames();
    obs_t o;
    logic [15:0] b [3];
    int          n [3];
    b[0] = 16'b010001;   n[0] = 6;
    b[1] = 16'b01000101; n[1] = 8;
    b[2] = 16'b01_11001; n[2] = 7;
    do_reset();
    for (int f = 0; f < 3; f++) begin
      run_frame(b[f], n[f], o);
      n_cmp++;
      if (o.n_ok !== 0 || o.n_err !== 1 || o.first !== 3) begin
        n_bad++;
        $display("FAIL bad_frame%0d ok=%0d err=%0d at=%0d expected 0/1/3", f, o.n_ok, o.n_err, o.first);
      end
      n_cmp++;
      if (led !== '0) begin
        n_bad++;
        $display("FAIL bad_frame%0d_led led=%h expected 000000", f, led);
      end
    end
  endtask

  task automatic test_bcast();
    obs_t o;
    do_reset();
    run_frame(16'b01_11111, 7, o);
    repeat (2) @(negedge clk);
    n_cmp++;
`ifdef LED_ARRAY_CTRL_BCAST_EN
    if (o.n_ok !== 1 || o.n_err !== 0 || o.first !== 3 || led !== 21'h1FFFFF) begin
      n_bad++;
      $display("FAIL bcast ok=%0d err=%0d at=%0d led=%h expected 1/0/3 led=1fffff", o.n_ok, o.n_err, o.first, led);
    end
`else
    if (o.n_ok !== 0 || o.n_err !== 1 || o.first !== 3 || led !== 21'h0) begin
      n_bad++;
      $display("FAIL bcast ok=%0d err=%0d at=%0d led=%h expected 0/1/3 led=000000", o.n_ok, o.n_err, o.first, led);
    end
`endif
    apply_model(16'b01_11111, 7);
  endtask

  task automatic test_reset_midframe();
    obs_t o;
    do_reset();
    run_frame(16'b01_00100, 7, o);
    n_cmp++;
    if (o.n_ok !== 1 || o.led4 !== 21'h000010) begin
      n_bad++;
      $display("FAIL midrst_setup ok=%0d led4=%h expected 1/000010", o.n_ok, o.led4);
    end
    @(negedge clk);
    latch = 1'b1;
    repeat (PH) @(negedge clk);
    send_bits(16'b111, 3);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (led !== '0) begin
      n_bad++;
      $display("FAIL midrst_async led=%h expected 000000", led);
    end
    latch = 1'b0; sclk = 1'b0; sdata = 1'b0;
    for (int i = 0; i < N_LEDS; i++) model[i] = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    run_frame(16'b01_00010, 7, o);
    n_cmp++;
    if (o.n_ok !== 1 || o.n_err !== 0 || o.first !== 3 || o.led4 !== 21'h000004) begin
      n_bad++;
      $display("FAIL midrst_after ok=%0d err=%0d at=%0d led4=%h expected 1/0/3 led=000004", o.n_ok, o.n_err, o.first, o.led4);
    end
    apply_model(16'b01_00010, 7);
  endtask

  task automatic test_random();
    obs_t o;
    logic [15:0] bits;
    logic [N_LEDS-1:0] old_exp;
    int nb, oc;
    do_reset();
    for (int f = 0; f < 24; f++) begin
      bits = 16'($urandom);
      nb   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 9)) : FW;
      oc   = outcome(bits, nb);
      run_frame(bits, nb, o);
      old_exp = exp_led(o.k3);
      n_cmp++;
      if (o.n_ok !== int'(oc > 0) || o.n_err !== int'(oc == 0) || o.first !== 3) begin
        n_bad++;
        $display("FAIL rand%0d_commit bits=%h n=%0d ok=%0d err=%0d at=%0d expected %0d/%0d/3",
                 f, bits, nb, o.n_ok, o.n_err, o.first, int'(oc > 0), int'(oc == 0));
      end
      n_cmp++;
      if (o.led3 !== old_exp) begin
        n_bad++;
        $display("FAIL rand%0d_led_hold led=%h expected %h", f, o.led3, old_exp);
      end
      apply_model(bits, nb);
      n_cmp++;
      if (o.led4 !== exp_led(o.k3 + 1)) begin
        n_bad++;
        $display("FAIL rand%0d_led_update led=%h expected %h", f, o.led4, exp_led(o.k3 + 1));
      end
      for (int s = 0; s < 6; s++) begin
        @(negedge clk);
        n_cmp++;
        if (led !== exp_led(tick)) begin
          n_bad++;
          $display("FAIL rand%0d_led s=%0d led=%h expected %h", f, s, led, exp_led(tick));
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; sdata = 1'b0; latch = 1'b0;
    test_reset();
    test_single_on();
    test_blink();
    test_bad_frames();
    test_bcast();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

endmodule
